// File: rtl/fp_mul_param_if.sv
// rtl/fp_mul_param_if.sv - request/result bundle for the fp_mul_param multiplier
//
// Purpose: groups the start request, the two operands and the registered result
// with its status flags, so requester and multiplier connect through one port.
//
// Signals:
//   start_i      requester -> multiplier  request a multiplication (sampled in IDLE)
//   a_i, b_i     requester -> multiplier  operands {sign, exp, frac}, W bits each
//   busy_o       multiplier -> requester  high whenever the multiplier is not IDLE
//   done_o       multiplier -> requester  one-cycle pulse, result valid
//   product_o    multiplier -> requester  registered result word
//   nan_o, infinit_o, overflow_o, underflow_o, inexact_o
//                multiplier -> requester  registered status flags
//
// Modports: master (requester side), slave (multiplier side).
interface fp_mul_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] product_o;
    logic         nan_o;
    logic         infinit_o;
    logic         overflow_o;
    logic         underflow_o;
    logic         inexact_o;

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, product_o,
        input  nan_o, infinit_o, overflow_o, underflow_o, inexact_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, product_o,
        output nan_o, infinit_o, overflow_o, underflow_o, inexact_o
    );
endinterface

// File: rtl/fp_mul_param.sv
// rtl/fp_mul_param.sv - multi-cycle parameterised IEEE-754-style floating point multiplier
//
// Purpose: multiplies two {sign, exp, frac} operands over a fixed five-state
// sequence IDLE -> UNPACK -> MULT -> NORM -> DONE. Subnormal inputs are read as
// signed zero and subnormal results are flushed to zero.
//
// Ports:
//   clk    single clock, rising edge
//   rst    asynchronous, active-high reset
//   bus    fp_mul_param_if.slave: start_i, a_i, b_i in; busy_o, done_o,
//          product_o and nan_o/infinit_o/overflow_o/underflow_o/inexact_o out
//
// Parameters: EXP_W exponent width (>= 4), MAN_W stored fraction width (>= 4).
//
// Compile-time option: define FP_MUL_ROUND_EN for round-to-nearest-even;
// otherwise the result is truncated. Latency and flags are the same either way.
module fp_mul_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic           clk,
    input  logic           rst,
    fp_mul_param_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = EXP_W + 2;        // signed working exponent width
    localparam int PW = 2 * MAN_W + 2;    // full significand product width

    localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Operands captured at acceptance so later input changes cannot leak in.
    logic [W-1:0]           a_r;
    logic [W-1:0]           b_r;

    // UNPACK results
    logic                   sign_r;
    logic signed [XW-1:0]   exp_r;
    logic [MAN_W:0]         ma_r;
    logic [MAN_W:0]         mb_r;
    logic                   cls_nan_r;
    logic                   cls_inf_r;
    logic                   cls_zero_r;

    // MULT result
    logic [PW-1:0]          prod_r;

    // Registered outputs
    logic [W-1:0]           product_q;
    logic                   nan_q;
    logic                   inf_q;
    logic                   ovf_q;
    logic                   unf_q;
    logic                   inx_q;

    //------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start_i) state_d = S_UNPACK;
            S_UNPACK: state_d = S_MULT;
            S_MULT:   state_d = S_NORM;
            S_NORM:   state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign bus.busy_o = (state_q != S_IDLE);
    assign bus.done_o = (state_q == S_DONE);

    //------------------------------------------------------------------
    // UNPACK: classify operands and form sign / unbiased-sum exponent
    //------------------------------------------------------------------
    logic [EXP_W-1:0]       ea;
    logic [EXP_W-1:0]       eb;
    logic [MAN_W-1:0]       fa;
    logic [MAN_W-1:0]       fb;
    logic                   a_nan, a_inf, a_zero;
    logic                   b_nan, b_inf, b_zero;
    logic                   u_nan, u_inf, u_zero;
    logic signed [XW-1:0]   exp_sum;

    always_comb begin
        ea     = a_r[MAN_W +: EXP_W];
        eb     = b_r[MAN_W +: EXP_W];
        fa     = a_r[0 +: MAN_W];
        fb     = b_r[0 +: MAN_W];
        // An all-zero exponent covers both true zero and subnormals (DAZ).
        a_zero = ~|ea;
        b_zero = ~|eb;
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        // Priority NaN > infinity > zero is resolved here so NORM only has
        // to look at one class bit at a time.
        u_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        u_inf  = (a_inf | b_inf) & ~u_nan;
        u_zero = (a_zero | b_zero) & ~u_nan & ~u_inf;
        exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    end

    //------------------------------------------------------------------
    // NORM: normalise, round, detect range, select final word and flags
    //------------------------------------------------------------------
    logic [PW-1:0]          prod_sh;
    logic [MAN_W:0]         mant_n;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;
    logic [MAN_W+1:0]       mant_rnd;
    logic                   rnd_carry;
    logic [MAN_W-1:0]       frac_f;
    logic signed [XW-1:0]   exp_n;
    logic signed [XW-1:0]   exp_f;
    logic [W-1:0]           res_word;
    logic                   res_nan, res_inf, res_ovf, res_unf, res_inx;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); when it reaches
        // 2 the MSB is set and the value is taken one position higher.
        prod_sh = prod_r[PW-1] ? prod_r : (prod_r << 1);
        exp_n   = exp_r + {{(XW-1){1'b0}}, prod_r[PW-1]};
        mant_n  = prod_sh[PW-1:MAN_W+1];
        guard   = prod_sh[MAN_W];
        sticky  = |prod_sh[MAN_W-1:0];
`ifdef FP_MUL_ROUND_EN
        round_up = guard & (sticky | mant_n[0]);
`else
        round_up = 1'b0;
`endif
        mant_rnd  = {1'b0, mant_n} + {{(MAN_W+1){1'b0}}, round_up};
        // A carry out of rounding leaves 10.00..0; the stored fraction is
        // then all zeros and the exponent moves up by one.
        rnd_carry = mant_rnd[MAN_W+1];
        frac_f    = rnd_carry ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
        exp_f     = exp_n + {{(XW-1){1'b0}}, rnd_carry};

        res_word = '0;
        res_nan  = 1'b0;
        res_inf  = 1'b0;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_inx  = 1'b0;

        if (cls_nan_r) begin
            res_word = QNAN;
            res_nan  = 1'b1;
        end else if (cls_inf_r) begin
            res_word = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
            res_inf  = 1'b1;
        end else if (cls_zero_r) begin
            res_word = {sign_r, {(W-1){1'b0}}};
        end else if (exp_f >= EXP_MAX) begin
            res_word = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
            res_ovf  = 1'b1;
            res_inx  = 1'b1;
        end else if (exp_f[XW-1] || (exp_f == '0)) begin
            res_word = {sign_r, {(W-1){1'b0}}};
            res_unf  = 1'b1;
            res_inx  = 1'b1;
        end else begin
            res_word = {sign_r, exp_f[EXP_W-1:0], frac_f};
            res_inx  = guard | sticky;
        end
    end

    //------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            sign_r     <= 1'b0;
            exp_r      <= '0;
            ma_r       <= '0;
            mb_r       <= '0;
            cls_nan_r  <= 1'b0;
            cls_inf_r  <= 1'b0;
            cls_zero_r <= 1'b0;
            prod_r     <= '0;
            product_q  <= '0;
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        a_r <= bus.a_i;
                        b_r <= bus.b_i;
                    end
                end
                S_UNPACK: begin
                    sign_r     <= a_r[W-1] ^ b_r[W-1];
                    exp_r      <= exp_sum;
                    ma_r       <= {1'b1, fa};
                    mb_r       <= {1'b1, fb};
                    cls_nan_r  <= u_nan;
                    cls_inf_r  <= u_inf;
                    cls_zero_r <= u_zero;
                end
                S_MULT: begin
                    prod_r <= PW'(ma_r) * PW'(mb_r);
                end
                S_NORM: begin
                    product_q <= res_word;
                    nan_q     <= res_nan;
                    inf_q     <= res_inf;
                    ovf_q     <= res_ovf;
                    unf_q     <= res_unf;
                    inx_q     <= res_inx;
                end
                default: ;
            endcase
        end
    end

    assign bus.product_o   = product_q;
    assign bus.nan_o       = nan_q;
    assign bus.infinit_o   = inf_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;
    assign bus.inexact_o   = inx_q;
endmodule

// File: tb/tb_fp_mul_param.sv
// tb/tb_fp_mul_param.sv - scoreboard bench for fp_mul_param with directed vectors
module tb_fp_mul_param;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    fp_mul_param_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_mul_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // flags packed as {nan, inf, overflow, underflow, inexact}
    typedef struct {
        logic [W-1:0] p;
        logic [4:0]   f;
        int           c;
    } exp_t;

    exp_t sbq[$];

`ifdef FP_MUL_ROUND_EN
    localparam logic [W-1:0] RND_EXP = 32'h40100002;
`else
    localparam logic [W-1:0] RND_EXP = 32'h40100001;
`endif

    function automatic logic [4:0] flags_now();
        return {bus.nan_o, bus.infinit_o, bus.overflow_o, bus.underflow_o, bus.inexact_o};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Caller must be at a negedge. Presents one request, then scrambles the
    // operands; when poke is set, also raises start_i while busy.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] p, input logic [4:0] f, input bit poke);
        exp_t e;
        bus.start_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        e.p = p;
        e.f = f;
        e.c = cyc;
        sbq.push_back(e);
        @(negedge clk);
        bus.start_i = poke;
        bus.a_i     = $urandom;
        bus.b_i     = $urandom;
        @(negedge clk);
        bus.a_i     = 32'h7F000000;
        bus.b_i     = 32'h7F000000;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: timeout waiting for done_o, got pending=%0d expected 0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic run(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] p, input logic [4:0] f, input bit poke);
        @(negedge clk);
        issue(a, b, p, f, poke);
        wait_done(nm);
    endtask

    initial begin
        exp_t e;
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.done_o) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done_o=1 expected 0 at cycle %0d", cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("product", 64'(bus.product_o), 64'(e.p));
                        chk("flags", 64'(flags_now()), 64'(e.f));
                        chk("latency", 64'(cyc - e.c), 64'd4);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_product", 64'(bus.product_o), 64'd0);
        chk("reset_flags", 64'(flags_now()), 64'd0);
        chk("reset_busy", 64'(bus.busy_o), 64'd0);
        chk("reset_done", 64'(bus.done_o), 64'd0);
        rst = 1'b0;

        run("mul_1p5_2",    32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 1'b0);
        run("nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1'b0);
        run("inf_x_zero",   32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10000, 1'b0);
        run("neg_inf",      32'hFF800000, 32'h40000000, 32'hFF800000, 5'b01000, 1'b0);
        run("overflow",     32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b00101, 1'b0);
        run("underflow",    32'h00800000, 32'h00800000, 32'h00000000, 5'b00011, 1'b0);
        run("round",        32'h3FC00001, 32'h3FC00001, RND_EXP,      5'b00001, 1'b0);
        run("neg_zero",     32'h80000000, 32'h3F800000, 32'h80000000, 5'b00000, 1'b0);
        run("daz",          32'h00000001, 32'h7F000000, 32'h00000000, 5'b00000, 1'b0);
        run("nan_over_0",   32'h7FC00000, 32'h00000000, 32'h7FC00000, 5'b10000, 1'b0);
        run("inf_x_inf",    32'h7F800000, 32'h7F800000, 32'h7F800000, 5'b01000, 1'b0);
        run("one_x_one",    32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 1'b0);
        run("neg3_x_4",     32'hC0400000, 32'h40800000, 32'hC1400000, 5'b00000, 1'b1);

        repeat (3) @(negedge clk);
        chk("hold_product", 64'(bus.product_o), 64'hC1400000);
        chk("hold_busy", 64'(bus.busy_o), 64'd0);

        // Reset in MULT: abandon the operation, clear everything, then a
        // start presented right as reset drops must be taken.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 32'h40400000;
        bus.b_i     = 32'h40400000;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_product", 64'(bus.product_o), 64'd0);
        chk("rst_mid_flags", 64'(flags_now()), 64'd0);
        chk("rst_mid_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_mid_done", 64'(bus.done_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 1'b0);
        wait_done("after_rst");

        repeat (6) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
